// File: rtl/uart_resp_pkg.sv
// Shared types and helpers for the UART responder: FSM state encodings,
// baud counter width and the parity generator used by both framers.
package uart_resp_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  // Unused upper bits of data must be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_resp_fifo.sv
// Small synchronous FIFO for the echo path. Read data is show-ahead;
// push on full and pop on empty are ignored.
module uart_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/uart_resp_slave.sv
// UART responder: receives frames on rx, buffers accepted characters and
// echoes them (XORed with ECHO_XOR) on tx, gated by tx_en.
module uart_resp_slave
  import uart_resp_pkg::*;
#(
  parameter int                   BAUD_DIV   = 16,
  parameter int                   DATA_BITS  = 8,
  parameter int                   PARITY_EN  = 0,
  parameter int                   PARITY_ODD = 0,
  parameter int                   STOP_BITS  = 1,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [DATA_BITS-1:0] ECHO_XOR   = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          tx_en,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic             ODD         = (PARITY_ODD != 0);

  logic [1:0] rx_sync_q;
  logic       rx_prev_q;
  logic       rx_s, rx_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_prev_q <= rx_sync_q[1];
    end
  end

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overflow_q, overflow_d;
  logic                 rx_tc;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    rx_par_d     = rx_par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overflow_d   = 1'b0;
    fifo_push    = 1'b0;
    rx_tc        = (rx_cnt_q == '0);
    if (rx_state_q != R_IDLE) rx_cnt_d = rx_tc ? BAUD_RELOAD : rx_cnt_q - CNT_W'(1);
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_fall) begin
          rx_state_d = R_START;
          rx_cnt_d   = HALF_RELOAD;
        end
      end
      R_START: begin
        if (rx_tc) begin
          rx_state_d = rx_s ? R_IDLE : R_DATA;
          rx_bit_d   = '0;
        end
      end
      R_DATA: begin
        if (rx_tc) begin
          rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY_EN != 0) ? R_PAR : R_STOP;
        end
      end
      R_PAR: begin
        if (rx_tc) begin
          rx_par_d   = rx_s;
          rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        // Back to idle on the sampling edge so a new start can be caught
        // in the second half of the stop bit.
        if (rx_tc) begin
          rx_state_d = R_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if ((PARITY_EN != 0) && (rx_par_q != parity_bit(8'(rx_sh_q), ODD))) begin
            parity_err_d = 1'b1;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            if (fifo_full) overflow_d = 1'b1;
            else           fifo_push  = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_par_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_par_q     <= rx_par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  uart_resp_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (rx_sh_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
  logic                 tx_tc;
  logic [DATA_BITS-1:0] echo_w;

  assign echo_w = fifo_rdata ^ ECHO_XOR;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    tx_tc      = (tx_cnt_q == '0);
    if (tx_state_q != T_IDLE) tx_cnt_d = tx_tc ? BAUD_RELOAD : tx_cnt_q - CNT_W'(1);
    unique case (tx_state_q)
      T_IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_sh_d    = echo_w;
          tx_par_d   = parity_bit(8'(echo_w), ODD);
          tx_d       = 1'b0;
          tx_cnt_d   = BAUD_RELOAD;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_tc) begin
          tx_d       = tx_sh_q[0];
          tx_bit_d   = '0;
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_tc) begin
          if (tx_bit_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d       = tx_par_q;
              tx_state_d = T_PAR;
            end else begin
              tx_d       = 1'b1;
              tx_stop_d  = 1'b0;
              tx_state_d = T_STOP;
            end
          end else begin
            tx_d     = tx_sh_q[1];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      T_PAR: begin
        if (tx_tc) begin
          tx_d       = 1'b1;
          tx_stop_d  = 1'b0;
          tx_state_d = T_STOP;
        end
      end
      T_STOP: begin
        tx_d = 1'b1;
        if (tx_tc) begin
          if (tx_stop_q == LAST_STOP) tx_state_d = T_IDLE;
          else                        tx_stop_d  = 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_resp_slave.sv
// Directed bench for uart_resp_slave: three instances (defaults; 7-bit with
// 2 stop bits and XOR echo; even parity) driven from a vector table.
module tb_uart_resp_slave;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rx_v [3];
  logic       tx_v [3];
  logic       txen_v [3];
  logic       rxv [3];
  logic       ferr [3];
  logic       perr [3];
  logic       ovf [3];
  logic [2:0] lvl [3];
  logic [7:0] rd0, rd2;
  logic [6:0] rd1;
  logic [7:0] rdat [3];

  assign rdat[0] = rd0;
  assign rdat[1] = {1'b0, rd1};
  assign rdat[2] = rd2;

  uart_resp_slave u0 (
    .clk(clk), .reset_n(rst_n), .rx(rx_v[0]), .tx(tx_v[0]), .tx_en(txen_v[0]),
    .rx_valid(rxv[0]), .rx_data(rd0), .frame_err(ferr[0]), .parity_err(perr[0]),
    .overflow(ovf[0]), .fifo_level(lvl[0])
  );

  uart_resp_slave #(.DATA_BITS(7), .STOP_BITS(2), .ECHO_XOR(7'h7F)) u1 (
    .clk(clk), .reset_n(rst_n), .rx(rx_v[1]), .tx(tx_v[1]), .tx_en(txen_v[1]),
    .rx_valid(rxv[1]), .rx_data(rd1), .frame_err(ferr[1]), .parity_err(perr[1]),
    .overflow(ovf[1]), .fifo_level(lvl[1])
  );

  uart_resp_slave #(.PARITY_EN(1), .PARITY_ODD(0)) u2 (
    .clk(clk), .reset_n(rst_n), .rx(rx_v[2]), .tx(tx_v[2]), .tx_en(txen_v[2]),
    .rx_valid(rxv[2]), .rx_data(rd2), .frame_err(ferr[2]), .parity_err(perr[2]),
    .overflow(ovf[2]), .fifo_level(lvl[2])
  );

  int cyc = 0;
  int n_val [3] = '{0, 0, 0};
  int n_ferr [3] = '{0, 0, 0};
  int n_perr [3] = '{0, 0, 0};
  int n_ovf [3] = '{0, 0, 0};
  int last_val [3] = '{0, 0, 0};
  logic [2:0] lvl_at_val [3];
  logic [7:0] ovf_data [3];
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (rxv[s]) begin
        n_val[s]      <= n_val[s] + 1;
        last_val[s]   <= cyc;
        lvl_at_val[s] <= lvl[s];
      end
      if (ferr[s]) n_ferr[s] <= n_ferr[s] + 1;
      if (perr[s]) n_perr[s] <= n_perr[s] + 1;
      if (ovf[s]) begin
        n_ovf[s]    <= n_ovf[s] + 1;
        ovf_data[s] <= rdat[s];
      end
    end
  end

  typedef struct {
    int         s;
    logic [7:0] d;
    logic       p;
    logic       ok;
    int         st;
  } cap_t;
  cap_t capq[$];

  // Decodes echoed frames by mid-bit sampling; stop bits must stay high
  // for their whole duration. Frames cut by reset are discarded.
  task automatic tx_mon(input int s, input int db, input int pe, input int sb);
    int nb, st;
    logic [7:0] d;
    logic p, ok, ab;
    nb = 1 + db + pe;
    forever begin
      @(negedge clk);
      if (rst_n && tx_v[s] == 1'b0) begin
        st = cyc; d = '0; p = 1'b0; ok = 1'b1; ab = 1'b0;
        for (int k = 1; k < (nb + sb) * BAUD; k++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          if (k == BAUD / 2 && tx_v[s] !== 1'b0) ok = 1'b0;
          if (k % BAUD == BAUD / 2) begin
            if (k / BAUD >= 1 && k / BAUD <= db) d[k / BAUD - 1] = tx_v[s];
            else if (pe != 0 && k / BAUD == db + 1) p = tx_v[s];
          end
          if (k >= nb * BAUD && tx_v[s] !== 1'b1) ok = 1'b0;
        end
        if (!ab) capq.push_back('{s, d, p, ok, st});
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(input int s, input logic v);
    rx_v[s] = v;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input int s, input logic [7:0] data, input int nbits,
                            input int par, input logic stop);
    bit_out(s, 1'b0);
    for (int i = 0; i < nbits; i++) bit_out(s, data[i]);
    if (par >= 0) bit_out(s, par[0]);
    bit_out(s, stop);
    rx_v[s] = 1'b1;
  endtask

  typedef struct {
    int         s;
    logic [7:0] data;
    int         nbits;
    int         par;
    logic       stop;
    int         e_val;
    int         e_ferr;
    int         e_perr;
    logic [7:0] e_rxd;
    int         e_echo;
    logic [7:0] e_edata;
    logic       e_epar;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    vec_t v;
    cap_t c;
    int b_val, b_ferr, b_perr, b_cap, b_ovf;

    //        s  data  nb  par stop val fe pe rxd   echo edata epar
    vt[0]  = '{0, 8'h55, 8, -1, 1'b1, 1, 0, 0, 8'h55, 1, 8'h55, 1'b0};
    vt[1]  = '{0, 8'hA3, 8, -1, 1'b1, 1, 0, 0, 8'hA3, 1, 8'hA3, 1'b0};
    vt[2]  = '{0, 8'h00, 8, -1, 1'b1, 1, 0, 0, 8'h00, 1, 8'h00, 1'b0};
    vt[3]  = '{0, 8'hFF, 8, -1, 1'b1, 1, 0, 0, 8'hFF, 1, 8'hFF, 1'b0};
    vt[4]  = '{1, 8'h2A, 7, -1, 1'b1, 1, 0, 0, 8'h2A, 1, 8'h55, 1'b0};
    vt[5]  = '{1, 8'h7F, 7, -1, 1'b1, 1, 0, 0, 8'h7F, 1, 8'h00, 1'b0};
    vt[6]  = '{2, 8'h01, 8,  0, 1'b1, 0, 0, 1, 8'h00, 0, 8'h00, 1'b0};
    vt[7]  = '{2, 8'h01, 8,  1, 1'b1, 1, 0, 0, 8'h01, 1, 8'h01, 1'b1};
    vt[8]  = '{2, 8'h03, 8,  0, 1'b1, 1, 0, 0, 8'h03, 1, 8'h03, 1'b0};
    vt[9]  = '{0, 8'h5A, 8, -1, 1'b0, 0, 1, 0, 8'hFF, 0, 8'h00, 1'b0};
    vt[10] = '{2, 8'h80, 8,  0, 1'b0, 0, 1, 0, 8'h03, 0, 8'h00, 1'b0};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rx_v[s]   = 1'b1;
      txen_v[s] = 1'b1;
    end
    fork
      tx_mon(0, 8, 0, 1);
      tx_mon(1, 7, 0, 2);
      tx_mon(2, 8, 1, 1);
    join_none
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_tx%0d", s), int'(tx_v[s]), 1);
      chk($sformatf("rst_valid%0d", s), int'(rxv[s]), 0);
      chk($sformatf("rst_rxdata%0d", s), int'(rdat[s]), 0);
      chk($sformatf("rst_level%0d", s), int'(lvl[s]), 0);
      chk($sformatf("rst_errs%0d", s), int'({ferr[s], perr[s], ovf[s]}), 0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      b_val = n_val[v.s]; b_ferr = n_ferr[v.s]; b_perr = n_perr[v.s];
      b_cap = capq.size();
      send_frame(v.s, v.data, v.nbits, v.par, v.stop);
      repeat (260) @(negedge clk);
      chk($sformatf("v%0d_valid", i), n_val[v.s] - b_val, v.e_val);
      chk($sformatf("v%0d_frame_err", i), n_ferr[v.s] - b_ferr, v.e_ferr);
      chk($sformatf("v%0d_parity_err", i), n_perr[v.s] - b_perr, v.e_perr);
      chk($sformatf("v%0d_rx_data", i), int'(rdat[v.s]), int'(v.e_rxd));
      chk($sformatf("v%0d_echo_count", i), capq.size() - b_cap, v.e_echo);
      if (v.e_echo != 0 && capq.size() > b_cap) begin
        c = capq[b_cap];
        chk($sformatf("v%0d_echo_inst", i), c.s, v.s);
        chk($sformatf("v%0d_echo_data", i), int'(c.d), int'(v.e_edata));
        chk($sformatf("v%0d_echo_par", i), int'(c.p), int'(v.e_epar));
        chk($sformatf("v%0d_echo_framing", i), int'(c.ok), 1);
        chk($sformatf("v%0d_echo_latency", i), c.st - last_val[v.s], 1);
        chk($sformatf("v%0d_level_at_valid", i), int'(lvl_at_val[v.s]), 1);
      end
      chk($sformatf("v%0d_level_end", i), int'(lvl[v.s]), 0);
    end

    // 4-clock glitch: must be rejected as a false start, then a real frame.
    b_val = n_val[0]; b_ferr = n_ferr[0]; b_perr = n_perr[0]; b_cap = capq.size();
    rx_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_pulses", (n_val[0] - b_val) + (n_ferr[0] - b_ferr) + (n_perr[0] - b_perr), 0);
    chk("glitch_echo", capq.size() - b_cap, 0);
    send_frame(0, 8'h3C, 8, -1, 1'b1);
    repeat (260) @(negedge clk);
    chk("post_glitch_valid", n_val[0] - b_val, 1);
    chk("post_glitch_echo_count", capq.size() - b_cap, 1);
    if (capq.size() > b_cap) chk("post_glitch_echo_data", int'(capq[b_cap].d), 'h3C);

    // Back-pressure and overflow on a 4-deep FIFO.
    txen_v[0] = 1'b0;
    b_val = n_val[0]; b_ovf = n_ovf[0]; b_cap = capq.size();
    for (int j = 0; j < 5; j++) begin
      send_frame(0, 8'(8'h10 + j), 8, -1, 1'b1);
      repeat (20) @(negedge clk);
    end
    chk("ovf_level_full", int'(lvl[0]), 4);
    chk("ovf_pulses", n_ovf[0] - b_ovf, 1);
    chk("ovf_char", int'(ovf_data[0]), 'h14);
    chk("ovf_valid_count", n_val[0] - b_val, 5);
    chk("ovf_rx_data", int'(rdat[0]), 'h14);
    chk("ovf_no_echo_while_blocked", capq.size() - b_cap, 0);
    txen_v[0] = 1'b1;
    repeat (4 * 162 + 40) @(negedge clk);
    chk("drain_echo_count", capq.size() - b_cap, 4);
    for (int j = 0; j < 4; j++) begin
      if (capq.size() > b_cap + j)
        chk($sformatf("drain_data%0d", j), int'(capq[b_cap + j].d), 'h10 + j);
    end
    chk("drain_level", int'(lvl[0]), 0);

    // Reset in the middle of an echo with one character still queued.
    txen_v[0] = 1'b0;
    send_frame(0, 8'h33, 8, -1, 1'b1);
    repeat (20) @(negedge clk);
    send_frame(0, 8'h44, 8, -1, 1'b1);
    repeat (20) @(negedge clk);
    chk("pre_reset_level", int'(lvl[0]), 2);
    b_cap = capq.size();
    txen_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_tx_low", int'(tx_v[0]), 0);
    chk("pre_reset_level_after_pop", int'(lvl[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx_async", int'(tx_v[0]), 1);
    chk("reset_level_async", int'(lvl[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(0, 8'h0F, 8, -1, 1'b1);
    repeat (260) @(negedge clk);
    chk("post_reset_echo_count", capq.size() - b_cap, 1);
    if (capq.size() > b_cap) chk("post_reset_echo_data", int'(capq[b_cap].d), 'h0F);
    chk("post_reset_rx_data", int'(rdat[0]), 'h0F);
    chk("post_reset_level", int'(lvl[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
